// File: rtl/aes_pkg.sv
// Shared AES-128 types, constants and GF(2^8) helper functions.
package aes_pkg;

    localparam int NR = 10;

    typedef logic [7:0]   byte_t;
    typedef logic [31:0]  word_t;
    typedef logic [127:0] state_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } ctrl_state_e;

    // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic byte_t xtime(input byte_t b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // MixColumns on one column; byte a0 sits in bits [31:24] (row 0).
    function automatic word_t mix_column(input word_t col);
        byte_t a0, a1, a2, a3;
        byte_t b0, b1, b2, b3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        return {b0, b1, b2, b3};
    endfunction

    // MixColumns over the four columns of the state.
    function automatic state_t mix_columns(input state_t s);
        state_t o;
        for (int c = 0; c < 4; c++) begin
            o[127 - 32 * c -: 32] = mix_column(s[127 - 32 * c -: 32]);
        end
        return o;
    endfunction

    // Row r rotates left by r bytes; byte (r,c) lives at bits [127-8*(r+4c) -: 8].
    function automatic state_t shift_rows(input state_t s);
        state_t o;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                o[127 - 8 * (r + 4 * c) -: 8] = s[127 - 8 * (r + 4 * ((c + r) % 4)) -: 8];
            end
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational forward AES S-box as a full lookup table.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    // Table lookup of the forward substitution.
    always_comb begin
        out_byte = 8'h00;
        case (in_byte)
            8'h00: out_byte = 8'h63;  8'h01: out_byte = 8'h7c;  8'h02: out_byte = 8'h77;  8'h03: out_byte = 8'h7b;
            8'h04: out_byte = 8'hf2;  8'h05: out_byte = 8'h6b;  8'h06: out_byte = 8'h6f;  8'h07: out_byte = 8'hc5;
            8'h08: out_byte = 8'h30;  8'h09: out_byte = 8'h01;  8'h0a: out_byte = 8'h67;  8'h0b: out_byte = 8'h2b;
            8'h0c: out_byte = 8'hfe;  8'h0d: out_byte = 8'hd7;  8'h0e: out_byte = 8'hab;  8'h0f: out_byte = 8'h76;
            8'h10: out_byte = 8'hca;  8'h11: out_byte = 8'h82;  8'h12: out_byte = 8'hc9;  8'h13: out_byte = 8'h7d;
            8'h14: out_byte = 8'hfa;  8'h15: out_byte = 8'h59;  8'h16: out_byte = 8'h47;  8'h17: out_byte = 8'hf0;
            8'h18: out_byte = 8'had;  8'h19: out_byte = 8'hd4;  8'h1a: out_byte = 8'ha2;  8'h1b: out_byte = 8'haf;
            8'h1c: out_byte = 8'h9c;  8'h1d: out_byte = 8'ha4;  8'h1e: out_byte = 8'h72;  8'h1f: out_byte = 8'hc0;
            8'h20: out_byte = 8'hb7;  8'h21: out_byte = 8'hfd;  8'h22: out_byte = 8'h93;  8'h23: out_byte = 8'h26;
            8'h24: out_byte = 8'h36;  8'h25: out_byte = 8'h3f;  8'h26: out_byte = 8'hf7;  8'h27: out_byte = 8'hcc;
            8'h28: out_byte = 8'h34;  8'h29: out_byte = 8'ha5;  8'h2a: out_byte = 8'he5;  8'h2b: out_byte = 8'hf1;
            8'h2c: out_byte = 8'h71;  8'h2d: out_byte = 8'hd8;  8'h2e: out_byte = 8'h31;  8'h2f: out_byte = 8'h15;
            8'h30: out_byte = 8'h04;  8'h31: out_byte = 8'hc7;  8'h32: out_byte = 8'h23;  8'h33: out_byte = 8'hc3;
            8'h34: out_byte = 8'h18;  8'h35: out_byte = 8'h96;  8'h36: out_byte = 8'h05;  8'h37: out_byte = 8'h9a;
            8'h38: out_byte = 8'h07;  8'h39: out_byte = 8'h12;  8'h3a: out_byte = 8'h80;  8'h3b: out_byte = 8'he2;
            8'h3c: out_byte = 8'heb;  8'h3d: out_byte = 8'h27;  8'h3e: out_byte = 8'hb2;  8'h3f: out_byte = 8'h75;
            8'h40: out_byte = 8'h09;  8'h41: out_byte = 8'h83;  8'h42: out_byte = 8'h2c;  8'h43: out_byte = 8'h1a;
            8'h44: out_byte = 8'h1b;  8'h45: out_byte = 8'h6e;  8'h46: out_byte = 8'h5a;  8'h47: out_byte = 8'ha0;
            8'h48: out_byte = 8'h52;  8'h49: out_byte = 8'h3b;  8'h4a: out_byte = 8'hd6;  8'h4b: out_byte = 8'hb3;
            8'h4c: out_byte = 8'h29;  8'h4d: out_byte = 8'he3;  8'h4e: out_byte = 8'h2f;  8'h4f: out_byte = 8'h84;
            8'h50: out_byte = 8'h53;  8'h51: out_byte = 8'hd1;  8'h52: out_byte = 8'h00;  8'h53: out_byte = 8'hed;
            8'h54: out_byte = 8'h20;  8'h55: out_byte = 8'hfc;  8'h56: out_byte = 8'hb1;  8'h57: out_byte = 8'h5b;
            8'h58: out_byte = 8'h6a;  8'h59: out_byte = 8'hcb;  8'h5a: out_byte = 8'hbe;  8'h5b: out_byte = 8'h39;
            8'h5c: out_byte = 8'h4a;  8'h5d: out_byte = 8'h4c;  8'h5e: out_byte = 8'h58;  8'h5f: out_byte = 8'hcf;
            8'h60: out_byte = 8'hd0;  8'h61: out_byte = 8'hef;  8'h62: out_byte = 8'haa;  8'h63: out_byte = 8'hfb;
            8'h64: out_byte = 8'h43;  8'h65: out_byte = 8'h4d;  8'h66: out_byte = 8'h33;  8'h67: out_byte = 8'h85;
            8'h68: out_byte = 8'h45;  8'h69: out_byte = 8'hf9;  8'h6a: out_byte = 8'h02;  8'h6b: out_byte = 8'h7f;
            8'h6c: out_byte = 8'h50;  8'h6d: out_byte = 8'h3c;  8'h6e: out_byte = 8'h9f;  8'h6f: out_byte = 8'ha8;
            8'h70: out_byte = 8'h51;  8'h71: out_byte = 8'ha3;  8'h72: out_byte = 8'h40;  8'h73: out_byte = 8'h8f;
            8'h74: out_byte = 8'h92;  8'h75: out_byte = 8'h9d;  8'h76: out_byte = 8'h38;  8'h77: out_byte = 8'hf5;
            8'h78: out_byte = 8'hbc;  8'h79: out_byte = 8'hb6;  8'h7a: out_byte = 8'hda;  8'h7b: out_byte = 8'h21;
            8'h7c: out_byte = 8'h10;  8'h7d: out_byte = 8'hff;  8'h7e: out_byte = 8'hf3;  8'h7f: out_byte = 8'hd2;
            8'h80: out_byte = 8'hcd;  8'h81: out_byte = 8'h0c;  8'h82: out_byte = 8'h13;  8'h83: out_byte = 8'hec;
            8'h84: out_byte = 8'h5f;  8'h85: out_byte = 8'h97;  8'h86: out_byte = 8'h44;  8'h87: out_byte = 8'h17;
            8'h88: out_byte = 8'hc4;  8'h89: out_byte = 8'ha7;  8'h8a: out_byte = 8'h7e;  8'h8b: out_byte = 8'h3d;
            8'h8c: out_byte = 8'h64;  8'h8d: out_byte = 8'h5d;  8'h8e: out_byte = 8'h19;  8'h8f: out_byte = 8'h73;
            8'h90: out_byte = 8'h60;  8'h91: out_byte = 8'h81;  8'h92: out_byte = 8'h4f;  8'h93: out_byte = 8'hdc;
            8'h94: out_byte = 8'h22;  8'h95: out_byte = 8'h2a;  8'h96: out_byte = 8'h90;  8'h97: out_byte = 8'h88;
            8'h98: out_byte = 8'h46;  8'h99: out_byte = 8'hee;  8'h9a: out_byte = 8'hb8;  8'h9b: out_byte = 8'h14;
            8'h9c: out_byte = 8'hde;  8'h9d: out_byte = 8'h5e;  8'h9e: out_byte = 8'h0b;  8'h9f: out_byte = 8'hdb;
            8'ha0: out_byte = 8'he0;  8'ha1: out_byte = 8'h32;  8'ha2: out_byte = 8'h3a;  8'ha3: out_byte = 8'h0a;
            8'ha4: out_byte = 8'h49;  8'ha5: out_byte = 8'h06;  8'ha6: out_byte = 8'h24;  8'ha7: out_byte = 8'h5c;
            8'ha8: out_byte = 8'hc2;  8'ha9: out_byte = 8'hd3;  8'haa: out_byte = 8'hac;  8'hab: out_byte = 8'h62;
            8'hac: out_byte = 8'h91;  8'had: out_byte = 8'h95;  8'hae: out_byte = 8'he4;  8'haf: out_byte = 8'h79;
            8'hb0: out_byte = 8'he7;  8'hb1: out_byte = 8'hc8;  8'hb2: out_byte = 8'h37;  8'hb3: out_byte = 8'h6d;
            8'hb4: out_byte = 8'h8d;  8'hb5: out_byte = 8'hd5;  8'hb6: out_byte = 8'h4e;  8'hb7: out_byte = 8'ha9;
            8'hb8: out_byte = 8'h6c;  8'hb9: out_byte = 8'h56;  8'hba: out_byte = 8'hf4;  8'hbb: out_byte = 8'hea;
            8'hbc: out_byte = 8'h65;  8'hbd: out_byte = 8'h7a;  8'hbe: out_byte = 8'hae;  8'hbf: out_byte = 8'h08;
            8'hc0: out_byte = 8'hba;  8'hc1: out_byte = 8'h78;  8'hc2: out_byte = 8'h25;  8'hc3: out_byte = 8'h2e;
            8'hc4: out_byte = 8'h1c;  8'hc5: out_byte = 8'ha6;  8'hc6: out_byte = 8'hb4;  8'hc7: out_byte = 8'hc6;
            8'hc8: out_byte = 8'he8;  8'hc9: out_byte = 8'hdd;  8'hca: out_byte = 8'h74;  8'hcb: out_byte = 8'h1f;
            8'hcc: out_byte = 8'h4b;  8'hcd: out_byte = 8'hbd;  8'hce: out_byte = 8'h8b;  8'hcf: out_byte = 8'h8a;
            8'hd0: out_byte = 8'h70;  8'hd1: out_byte = 8'h3e;  8'hd2: out_byte = 8'hb5;  8'hd3: out_byte = 8'h66;
            8'hd4: out_byte = 8'h48;  8'hd5: out_byte = 8'h03;  8'hd6: out_byte = 8'hf6;  8'hd7: out_byte = 8'h0e;
            8'hd8: out_byte = 8'h61;  8'hd9: out_byte = 8'h35;  8'hda: out_byte = 8'h57;  8'hdb: out_byte = 8'hb9;
            8'hdc: out_byte = 8'h86;  8'hdd: out_byte = 8'hc1;  8'hde: out_byte = 8'h1d;  8'hdf: out_byte = 8'h9e;
            8'he0: out_byte = 8'he1;  8'he1: out_byte = 8'hf8;  8'he2: out_byte = 8'h98;  8'he3: out_byte = 8'h11;
            8'he4: out_byte = 8'h69;  8'he5: out_byte = 8'hd9;  8'he6: out_byte = 8'h8e;  8'he7: out_byte = 8'h94;
            8'he8: out_byte = 8'h9b;  8'he9: out_byte = 8'h1e;  8'hea: out_byte = 8'h87;  8'heb: out_byte = 8'he9;
            8'hec: out_byte = 8'hce;  8'hed: out_byte = 8'h55;  8'hee: out_byte = 8'h28;  8'hef: out_byte = 8'hdf;
            8'hf0: out_byte = 8'h8c;  8'hf1: out_byte = 8'ha1;  8'hf2: out_byte = 8'h89;  8'hf3: out_byte = 8'h0d;
            8'hf4: out_byte = 8'hbf;  8'hf5: out_byte = 8'he6;  8'hf6: out_byte = 8'h42;  8'hf7: out_byte = 8'h68;
            8'hf8: out_byte = 8'h41;  8'hf9: out_byte = 8'h99;  8'hfa: out_byte = 8'h2d;  8'hfb: out_byte = 8'h0f;
            8'hfc: out_byte = 8'hb0;  8'hfd: out_byte = 8'h54;  8'hfe: out_byte = 8'hbb;  8'hff: out_byte = 8'h16;
            default: out_byte = 8'h00;
        endcase
    end

endmodule

// File: rtl/aes_cipher_top.sv
// Iterative AES-128 encryption core: one round per clock, on-the-fly key
// expansion, ciphertext presented with a single-cycle done pulse.
module aes_cipher_top
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         ld,
    input  logic [127:0] key,
    input  logic [127:0] text_in,
    output logic [127:0] text_out,
    output logic         done
);

    ctrl_state_e fsm_q, fsm_d;
    state_t      state_q, state_d;
    state_t      w_q, w_d;
    byte_t       rcon_q, rcon_d;
    logic [3:0]  cnt_q, cnt_d;
    state_t      text_out_q, text_out_d;
    logic        done_q, done_d;

    state_t      sub_bytes_s;
    state_t      shifted_s;
    state_t      mid_round_s;
    state_t      last_round_s;
    word_t       rot_w3_s;
    word_t       sub_word_s;
    word_t       temp_s;
    word_t       nk0_s, nk1_s, nk2_s, nk3_s;
    state_t      key_next_s;

    // SubBytes: one S-box per state byte.
    for (genvar i = 0; i < 16; i++) begin : g_sub_bytes
        aes_sbox u_sbox (
            .in_byte  (state_q[127 - 8 * i -: 8]),
            .out_byte (sub_bytes_s[127 - 8 * i -: 8])
        );
    end

    // SubWord for the key schedule, applied to RotWord(w3).
    assign rot_w3_s = {w_q[23:0], w_q[31:24]};
    for (genvar j = 0; j < 4; j++) begin : g_sub_word
        aes_sbox u_sbox (
            .in_byte  (rot_w3_s[31 - 8 * j -: 8]),
            .out_byte (sub_word_s[31 - 8 * j -: 8])
        );
    end

    // Next round key and both flavours of round output.
    always_comb begin
        temp_s       = sub_word_s ^ {rcon_q, 24'h000000};
        nk0_s        = w_q[127:96] ^ temp_s;
        nk1_s        = w_q[95:64]  ^ nk0_s;
        nk2_s        = w_q[63:32]  ^ nk1_s;
        nk3_s        = w_q[31:0]   ^ nk2_s;
        key_next_s   = {nk0_s, nk1_s, nk2_s, nk3_s};
        shifted_s    = shift_rows(sub_bytes_s);
        mid_round_s  = mix_columns(shifted_s) ^ key_next_s;
        last_round_s = shifted_s ^ key_next_s;
    end

    // Control: ld always wins (load or abort/restart); otherwise step one round.
    always_comb begin
        fsm_d      = fsm_q;
        state_d    = state_q;
        w_d        = w_q;
        rcon_d     = rcon_q;
        cnt_d      = cnt_q;
        text_out_d = text_out_q;
        done_d     = 1'b0;
        if (ld) begin
            state_d = text_in ^ key;
            w_d     = key;
            rcon_d  = 8'h01;
            cnt_d   = 4'(NR);
            fsm_d   = ST_BUSY;
        end else begin
            case (fsm_q)
                ST_IDLE: begin
                    fsm_d = ST_IDLE;
                end
                ST_BUSY: begin
                    w_d    = key_next_s;
                    rcon_d = xtime(rcon_q);
                    cnt_d  = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d    = last_round_s;
                        text_out_d = last_round_s;
                        done_d     = 1'b1;
                        fsm_d      = ST_IDLE;
                    end else begin
                        state_d = mid_round_s;
                    end
                end
                default: begin
                    fsm_d = ST_IDLE;
                end
            endcase
        end
    end

    // State, key schedule, control and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm_q      <= ST_IDLE;
            state_q    <= 128'h0;
            w_q        <= 128'h0;
            rcon_q     <= 8'h00;
            cnt_q      <= 4'd0;
            text_out_q <= 128'h0;
            done_q     <= 1'b0;
        end else begin
            fsm_q      <= fsm_d;
            state_q    <= state_d;
            w_q        <= w_d;
            rcon_q     <= rcon_d;
            cnt_q      <= cnt_d;
            text_out_q <= text_out_d;
            done_q     <= done_d;
        end
    end

    assign text_out = text_out_q;
    assign done     = done_q;

endmodule

// File: tb/tb_aes_cipher_top.sv
// Directed-vector bench for aes_cipher_top using published AES-128 vectors.
module tb_aes_cipher_top;

    logic         clk;
    logic         rst;
    logic         ld;
    logic [127:0] key;
    logic [127:0] text_in;
    logic [127:0] text_out;
    logic         done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [127:0] vk  [4];
    logic [127:0] vpt [4];
    logic [127:0] vct [4];

    aes_cipher_top dut (
        .clk      (clk),
        .rst      (rst),
        .ld       (ld),
        .key      (key),
        .text_in  (text_in),
        .text_out (text_out),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive ld for exactly one rising edge (the load edge E0).
    task automatic load(input logic [127:0] k, input logic [127:0] pt);
        @(negedge clk);
        ld      = 1'b1;
        key     = k;
        text_in = pt;
        @(negedge clk);
        ld      = 1'b0;
        key     = $urandom();
        text_in = {$urandom(), $urandom(), $urandom(), $urandom()};
    endtask

    // Load one vector and check done is low E1..E9, high at E10 with ct, low at E11.
    task automatic run_vector(input string tag, input logic [127:0] k,
                              input logic [127:0] pt, input logic [127:0] ct);
        load(k, pt);
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            #1;
            check_eq({tag, "_done"}, {127'd0, done}, {127'd0, (i == 10)});
        end
        check_eq({tag, "_ct"}, text_out, ct);
        @(posedge clk);
        #1;
        check_eq({tag, "_done_e11"}, {127'd0, done}, 128'd0);
    endtask

    initial begin
        vk[0]  = 128'h000102030405060708090a0b0c0d0e0f;
        vpt[0] = 128'h00112233445566778899aabbccddeeff;
        vct[0] = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        vk[1]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        vpt[1] = 128'h3243f6a8885a308d313198a2e0370734;
        vct[1] = 128'h3925841d02dc09fbdc118597196a0b32;
        vk[2]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        vpt[2] = 128'h6bc1bee22e409f96e93d7e117393172a;
        vct[2] = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
        vk[3]  = 128'h0;
        vpt[3] = 128'h0;
        vct[3] = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

        rst     = 1'b0;
        ld      = 1'b0;
        key     = 128'h0;
        text_in = 128'h0;
        #2;
        check_eq("reset_text_out", text_out, 128'h0);
        check_eq("reset_done", {127'd0, done}, 128'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Four vectors back to back, next ld five cycles after done; output must hold.
        for (int v = 0; v < 4; v++) begin
            run_vector($sformatf("vec%0d", v), vk[v], vpt[v], vct[v]);
            for (int g = 0; g < 3; g++) begin
                @(posedge clk);
                #1;
                check_eq($sformatf("vec%0d_hold", v), text_out, vct[v]);
                check_eq($sformatf("vec%0d_idle_done", v), {127'd0, done}, 128'd0);
            end
        end

        // Restart: A loaded, B loaded at E4; one done, 10 edges after B's load.
        load(vk[1], vpt[1]);
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk);
            #1;
            check_eq("restart_a_done", {127'd0, done}, 128'd0);
        end
        @(negedge clk);
        ld      = 1'b1;
        key     = vk[0];
        text_in = vpt[0];
        @(negedge clk);
        ld      = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            #1;
            check_eq("restart_done", {127'd0, done}, {127'd0, (i == 10)});
            if (i < 10) begin
                check_eq("restart_hold", text_out, vct[3]);
            end else begin
                check_eq("restart_ct", text_out, vct[0]);
            end
        end
        @(posedge clk);
        #1;
        check_eq("restart_done_e11", {127'd0, done}, 128'd0);

        // Async reset mid-operation between E5 and E6.
        load(vk[3], vpt[3]);
        for (int i = 1; i <= 5; i++) begin
            @(posedge clk);
        end
        #2;
        rst = 1'b0;
        #1;
        check_eq("midrst_text_out", text_out, 128'h0);
        check_eq("midrst_done", {127'd0, done}, 128'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            check_eq("midrst_no_done", {127'd0, done}, 128'd0);
        end
        check_eq("midrst_text_out_hold", text_out, 128'h0);
        run_vector("post_rst", vk[2], vpt[2], vct[2]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
